// File: rtl/bk_adder_io_stage.sv
// Registered operand/result wrapper around a combinational Brent-Kung adder netlist.
// Latency: accept edge E0, result captured at E0+SETTLE_CYCLES, out_valid visible the cycle after.
// Backpressure: result held while out_ready=0; in_ready drops until the result is taken.
module bk_adder_io_stage #(
    parameter int WIDTH         = 12,
    parameter int SETTLE_CYCLES = 1,
    parameter int CHECK_EN      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [2*WIDTH-1:0]   adder_in,
    input  logic [WIDTH:0]       adder_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_carry,
    output logic                 busy,
    output logic [15:0]          txn_count,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, SETTLE, OUTPUT} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } operand_t;

    // Counter reload value; SETTLE_CYCLES is limited to 1..4 so two bits suffice.
    localparam logic [1:0] SETTLE_LOAD = 2'(SETTLE_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;
    operand_t             ops;
    logic [1:0]           cnt;
    logic [2*WIDTH-1:0]   mix;
    logic [WIDTH:0]       ref_sum;
    logic                 accept;
    logic                 out_fire;
    logic                 capture;
    logic                 err_q;

    assign in_ready = (state == IDLE) || ((state == OUTPUT) && out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign capture  = (state == SETTLE) && (cnt == 2'd0);
    assign busy     = (state != IDLE);
    // Behavioural reference from the held operands, which are stable through the settle window.
    assign ref_sum  = {1'b0, ops.a} + {1'b0, ops.b};
    assign err      = (CHECK_EN != 0) ? err_q : 1'b0;

    // Bit-interleave the incoming operands into the netlist's input bus layout: {B[i], A[i]} pairs.
    always_comb begin
        mix = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mix[2*i]   = in_a[i];
            mix[2*i+1] = in_b[i];
        end
    end

    // Next-state logic; a result handshake with a simultaneous accept goes straight back to SETTLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETTLE;
            SETTLE:  if (cnt == 2'd0) state_nxt = OUTPUT;
            OUTPUT:  if (out_fire) state_nxt = accept ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand launch, settle countdown, result capture, handshake count and sticky mismatch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops       <= '0;
            adder_in  <= '0;
            cnt       <= 2'd0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
            txn_count <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                ops      <= '{a: in_a, b: in_b};
                adder_in <= mix;
                cnt      <= SETTLE_LOAD;
            end else if ((state == SETTLE) && (cnt != 2'd0)) begin
                cnt <= cnt - 2'd1;
            end

            if (capture) begin
                out_sum   <= adder_out[WIDTH-1:0];
                out_carry <= adder_out[WIDTH];
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (out_fire) begin
                txn_count <= txn_count + 16'd1;
            end

            // A mismatch is only flagged; the netlist value is still forwarded.
            if ((CHECK_EN != 0) && capture && (adder_out != ref_sum)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bk_adder_io_stage.sv
// Bench for bk_adder_io_stage: three instances with settle times 1, 3 and 4.
// Each instance drives a behavioural adder stand-in with optional bit-3 stuck-at-0.
// A per-instance scoreboard queues expected results on accept and checks them on output handshakes.
module tb_bk_adder_io_stage;
    localparam int W = 12;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic           rst       [N];
    logic           in_valid  [N];
    logic           in_ready  [N];
    logic [W-1:0]   in_a      [N];
    logic [W-1:0]   in_b      [N];
    logic [2*W-1:0] adder_in  [N];
    logic           out_valid [N];
    logic           out_ready [N];
    logic [W-1:0]   out_sum   [N];
    logic           out_carry [N];
    logic           busy      [N];
    logic [15:0]    txn_count [N];
    logic           err       [N];
    logic           fault     [N];

    logic [W:0]     exp_q   [N][$];
    logic [15:0]    txn_exp [N];
    logic           err_exp [N];

    function automatic int settle_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [W-1:0] na;
        logic [W-1:0] nb;
        logic [W:0]   net_out;
        logic [W:0]   e_v;
        logic [W:0]   s_v;
        logic [W:0]   f_v;

        bk_adder_io_stage #(
            .WIDTH(W),
            .SETTLE_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .CHECK_EN(1)
        ) u_dut (
            .clk(clk),
            .rst(rst[g]),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_a(in_a[g]),
            .in_b(in_b[g]),
            .adder_in(adder_in[g]),
            .adder_out(net_out),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_sum(out_sum[g]),
            .out_carry(out_carry[g]),
            .busy(busy[g]),
            .txn_count(txn_count[g]),
            .err(err[g])
        );

        // Adder netlist stand-in: de-interleave, add, optionally stick bit 3 at 0.
        always_comb begin
            na = '0;
            nb = '0;
            for (int i = 0; i < W; i++) begin
                na[i] = adder_in[g][2*i];
                nb[i] = adder_in[g][2*i+1];
            end
            net_out = {1'b0, na} + {1'b0, nb};
            if (fault[g]) net_out[3] = 1'b0;
        end

        // Monitor: check the output handshake first, then queue the expectation for a new accept.
        always @(negedge clk) begin
            if (rst[g]) begin
                exp_q[g].delete();
                txn_exp[g] = 16'd0;
                err_exp[g] = 1'b0;
            end else begin
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL d%0d_unexpected_output: got 0x%0h expected none", g,
                                 {out_carry[g], out_sum[g]});
                    end else begin
                        e_v = exp_q[g].pop_front();
                        chk($sformatf("d%0d_result", g), 32'({out_carry[g], out_sum[g]}), 32'(e_v));
                    end
                    chk($sformatf("d%0d_txn_at_fire", g), 32'(txn_count[g]), 32'(txn_exp[g]));
                    chk($sformatf("d%0d_err_at_fire", g), 32'(err[g]), 32'(err_exp[g]));
                    txn_exp[g] = txn_exp[g] + 16'd1;
                end
                if (in_valid[g] && in_ready[g]) begin
                    s_v = {1'b0, in_a[g]} + {1'b0, in_b[g]};
                    f_v = s_v;
                    if (fault[g]) f_v[3] = 1'b0;
                    if (f_v != s_v) err_exp[g] = 1'b1;
                    exp_q[g].push_back(f_v);
                end
            end
        end
    end

    task automatic chk_reset(int d);
        chk($sformatf("d%0d_rst_out_valid", d), 32'(out_valid[d]), 0);
        chk($sformatf("d%0d_rst_out_sum", d), 32'(out_sum[d]), 0);
        chk($sformatf("d%0d_rst_out_carry", d), 32'(out_carry[d]), 0);
        chk($sformatf("d%0d_rst_adder_in", d), 32'(adder_in[d]), 0);
        chk($sformatf("d%0d_rst_txn", d), 32'(txn_count[d]), 0);
        chk($sformatf("d%0d_rst_err", d), 32'(err[d]), 0);
        chk($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 0);
        chk($sformatf("d%0d_rst_in_ready", d), 32'(in_ready[d]), 1);
    endtask

    task automatic do_reset(int d);
        @(posedge clk); #1;
        rst[d] = 1'b1;
        @(posedge clk); #1;
        rst[d] = 1'b0;
        chk_reset(d);
    endtask

    // Present one operand pair and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic send(int d, logic [W-1:0] a, logic [W-1:0] b);
        int guard = 0;
        @(posedge clk); #1;
        in_valid[d] = 1'b1;
        in_a[d]     = a;
        in_b[d]     = b;
        forever begin
            @(negedge clk);
            if (in_ready[d]) break;
            guard++;
            if (guard >= 100) break;
        end
        if (guard >= 100) begin
            checks++;
            failures++;
            $display("FAIL d%0d_send_timeout: in_ready stayed 0 for %0d cycles, required 1", d, guard);
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic expect_out(int d, logic [W:0] e);
        int guard = 0;
        forever begin
            @(negedge clk);
            if (out_valid[d]) break;
            guard++;
            if (guard >= 50) break;
        end
        chk($sformatf("d%0d_out_valid_seen", d), 32'(out_valid[d]), 1);
        chk($sformatf("d%0d_out_value", d), 32'({out_carry[d], out_sum[d]}), 32'(e));
    endtask

    task automatic wait_drain(int d);
        int guard = 0;
        forever begin
            @(negedge clk);
            if (exp_q[d].size() == 0 && !out_valid[d]) break;
            guard++;
            if (guard >= 300) break;
        end
        chk($sformatf("d%0d_drained", d), 32'(exp_q[d].size()), 0);
    endtask

    // Continuous in_valid/out_ready stream; accepts must be spaced exactly SETTLE_CYCLES+1 apart.
    task automatic b2b(int d, int n);
        int   acc   = 0;
        int   first = 0;
        int   last  = 0;
        int   guard = 0;
        logic took;
        do_reset(d);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b1;
        in_a[d]     = W'($urandom);
        in_b[d]     = W'($urandom);
        while (acc < n && guard < n * 10) begin
            @(negedge clk);
            took = in_ready[d];
            guard++;
            if (took) begin
                if (acc == 0) first = cyc;
                last = cyc;
                acc++;
            end
            @(posedge clk); #1;
            if (took) begin
                in_a[d] = W'($urandom);
                in_b[d] = W'($urandom);
            end
        end
        in_valid[d] = 1'b0;
        chk($sformatf("d%0d_b2b_accepts", d), 32'(acc), 32'(n));
        chk($sformatf("d%0d_b2b_span", d), 32'(last - first), 32'((n - 1) * (settle_of(d) + 1)));
        wait_drain(d);
        chk($sformatf("d%0d_b2b_txn", d), 32'(txn_count[d]), 32'(n));
        chk($sformatf("d%0d_b2b_err", d), 32'(err[d]), 0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   held;

        for (int d = 0; d < N; d++) begin
            rst[d]       = 1'b1;
            in_valid[d]  = 1'b0;
            in_a[d]      = '0;
            in_b[d]      = '0;
            out_ready[d] = 1'b1;
            fault[d]     = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) rst[d] = 1'b0;
        for (int d = 0; d < N; d++) chk_reset(d);

        // Single op with carry out, latency and interleave check.
        send(0, 12'hFFF, 12'h001);
        @(negedge clk);
        chk("d0_adder_in_interleave", 32'(adder_in[0]), 32'h555557);
        chk("d0_valid_early", 32'(out_valid[0]), 0);
        chk("d0_busy_settle", 32'(busy[0]), 1);
        chk("d0_in_ready_settle", 32'(in_ready[0]), 0);
        @(negedge clk);
        chk("d0_valid_on_time", 32'(out_valid[0]), 1);
        chk("d0_fff_plus_1", 32'({out_carry[0], out_sum[0]}), 32'h1000);
        @(negedge clk);
        chk("d0_txn_after_one", 32'(txn_count[0]), 1);
        chk("d0_valid_cleared", 32'(out_valid[0]), 0);
        chk("d0_err_clean", 32'(err[0]), 0);

        // Two more directed sums.
        send(0, 12'hABC, 12'h123);
        expect_out(0, 13'h0BDF);
        send(0, 12'h800, 12'h800);
        expect_out(0, 13'h1000);
        wait_drain(0);

        // Backpressure: result held, in_ready low, stray in_valid pulses ignored.
        out_ready[0] = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        held = {1'b0, a} + {1'b0, b};
        send(0, a, b);
        expect_out(0, held);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid[0] = k[0];
            in_a[0]     = ~a;
            in_b[0]     = W'(k);
            @(negedge clk);
            chk("d0_bp_held", 32'({out_carry[0], out_sum[0]}), 32'(held));
            chk("d0_bp_in_ready", 32'(in_ready[0]), 0);
            chk("d0_bp_valid", 32'(out_valid[0]), 1);
        end
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("d0_bp_one_handshake", 32'(txn_count[0]), 4);
        chk("d0_bp_valid_after", 32'(out_valid[0]), 0);
        out_ready[0] = 1'b1;

        // Fault injection: stuck-at-0 on bit 3, then sticky err through clean ops.
        do_reset(0);
        fault[0] = 1'b1;
        send(0, 12'h008, 12'h000);
        expect_out(0, 13'h0000);
        fault[0] = 1'b0;
        @(negedge clk);
        chk("d0_err_set", 32'(err[0]), 1);
        for (int k = 0; k < 3; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            send(0, a, b);
            expect_out(0, {1'b0, a} + {1'b0, b});
        end
        wait_drain(0);
        chk("d0_err_sticky", 32'(err[0]), 1);
        do_reset(0);

        // Throughput at settle 1 and 3.
        b2b(0, 100);
        b2b(1, 100);

        // Reset mid-settle on the 4-cycle instance.
        a = W'($urandom);
        b = W'($urandom);
        send(2, a, b);
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        chk_reset(2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("d2_no_valid_after_rst", 32'(out_valid[2]), 0);
        end
        a = W'($urandom);
        b = W'($urandom);
        send(2, a, b);
        expect_out(2, {1'b0, a} + {1'b0, b});
        wait_drain(2);
        chk("d2_txn_after_rst", 32'(txn_count[2]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
